// File: rtl/dual_ram_be_pkg.sv
// Shared constants and FSM encoding for the byte-enable dual-port RAM.
// Imported by the interface, the storage core and the top level.
package dual_ram_be_pkg;

    localparam int BYTE_W           = 8;
    localparam int RAM_RD_PIPE      = 0;
    localparam int RAM_CLEAR_ON_RST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/dual_ram_be_if.sv
// Write/read request bus of the byte-enable RAM; the requester is the master,
// the RAM is the slave.
interface dual_ram_be_if
    import dual_ram_be_pkg::*;
#(
    parameter int DW       = 32,
    parameter int ADDR_BIT = 12
);
    logic                     wen_i;
    logic [DW/BYTE_W-1:0]     wbe_i;
    logic [ADDR_BIT-1:0]      waddr_i;
    logic [DW-1:0]            wdata_i;
    logic                     ren_i;
    logic [ADDR_BIT-1:0]      raddr_i;
    logic [DW-1:0]            rdata_o;
    logic                     rvalid_o;
    logic                     busy_o;

    modport master (
        output wen_i, wbe_i, waddr_i, wdata_i, ren_i, raddr_i,
        input  rdata_o, rvalid_o, busy_o
    );

    modport slave (
        input  wen_i, wbe_i, waddr_i, wdata_i, ren_i, raddr_i,
        output rdata_o, rvalid_o, busy_o
    );
endinterface

// File: rtl/dual_ram_be_core.sv
// Byte-enable storage array: one write port, one synchronous registered read port.
// No reset anywhere so that it maps onto block RAM.
module ram_be_core
    import dual_ram_be_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 4096,
    parameter int ADDR_BIT = 12
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DW/BYTE_W-1:0]    be,
    input  logic [ADDR_BIT-1:0]     waddr,
    input  logic [DW-1:0]           wdata,
    input  logic                    re,
    input  logic [ADDR_BIT-1:0]     raddr,
    output logic [DW-1:0]           rdata
);
    localparam int NB = DW / BYTE_W;

    logic [DW-1:0] mem [DEPTH];

    // Read returns the pre-write contents on a same-address collision;
    // the top level forwards the new lanes itself.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/dual_ram_be.sv
// Simple-dual-port RAM with byte enables, per-lane write forwarding, optional
// output register and an after-reset clear sequencer.
module dual_ram_be
    import dual_ram_be_pkg::*;
#(
    parameter int DW           = 32,
    parameter int DEPTH        = 4096,
    parameter int ADDR_BIT     = 12,
    parameter int RD_PIPE      = RAM_RD_PIPE,
    parameter int CLEAR_ON_RST = RAM_CLEAR_ON_RST
) (
    input  logic          clk,
    input  logic          rst,
    dual_ram_be_if.slave  bus
);
    localparam int                  NB         = DW / BYTE_W;
    localparam ram_state_e          RST_STATE  = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_BIT-1:0] a);
        return $unsigned(32'(a)) < $unsigned(DEPTH);
    endfunction

    function automatic logic [DW-1:0] merge_lanes(
        input logic [DW-1:0] mem_d,
        input logic [DW-1:0] fwd_d,
        input logic [NB-1:0] fwd_be
    );
        logic [DW-1:0] m;
        m = mem_d;
        for (int b = 0; b < NB; b++) begin
            if (fwd_be[b]) begin
                m[b*BYTE_W +: BYTE_W] = fwd_d[b*BYTE_W +: BYTE_W];
            end
        end
        return m;
    endfunction

    ram_state_e          state;
    logic [ADDR_BIT-1:0] clr_addr;
    logic                busy_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            clr_addr <= '0;
            busy_r   <= (CLEAR_ON_RST != 0);
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state    <= ST_READY;
                        busy_r   <= 1'b0;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    logic ready;
    logic wr_ok;
    logic rd_acc;
    logic rd_ok;
    logic hit;

    assign ready  = (state == ST_READY);
    assign wr_ok  = ready & bus.wen_i & (|bus.wbe_i) & in_range(bus.waddr_i);
    assign rd_acc = ready & bus.ren_i;
    assign rd_ok  = rd_acc & in_range(bus.raddr_i);
    assign hit    = rd_ok & bus.wen_i & (bus.raddr_i == bus.waddr_i);

    logic                core_we;
    logic [NB-1:0]       core_be;
    logic [ADDR_BIT-1:0] core_waddr;
    logic [DW-1:0]       core_wdata;
    logic [DW-1:0]       core_rdata;

    // The clear sequencer owns the write port until the array is zeroed.
    always_comb begin
        core_we    = wr_ok;
        core_be    = bus.wbe_i;
        core_waddr = bus.waddr_i;
        core_wdata = bus.wdata_i;
        if (!ready) begin
            core_we    = 1'b1;
            core_be    = '1;
            core_waddr = clr_addr;
            core_wdata = '0;
        end
    end

    ram_be_core #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .be    (core_be),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_ok),
        .raddr (bus.raddr_i),
        .rdata (core_rdata)
    );

    // ---- stage p1: array read, forwarding lanes captured alongside ----
    logic          vld_p1;
    logic          ok_p1;
    logic [NB-1:0] fwd_be_p1;
    logic [DW-1:0] fwd_data_p1;
    logic [DW-1:0] merged_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            ok_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                ok_p1 <= rd_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fwd_be_p1   <= hit ? bus.wbe_i : '0;
            fwd_data_p1 <= bus.wdata_i;
        end
    end

    // ok_p1 low covers both out-of-range reads and "no read since reset".
    assign merged_p1 = ok_p1 ? merge_lanes(core_rdata, fwd_data_p1, fwd_be_p1) : '0;

    // ---- stage p2: optional output register ----
    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic          vld_p2;
            logic [DW-1:0] rdata_p2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p2   <= 1'b0;
                    rdata_p2 <= '0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        rdata_p2 <= merged_p1;
                    end
                end
            end

            assign bus.rdata_o  = rdata_p2;
            assign bus.rvalid_o = vld_p2;
        end else begin : g_nopipe
            assign bus.rdata_o  = merged_p1;
            assign bus.rvalid_o = vld_p1;
        end
    endgenerate

    assign bus.busy_o = busy_r;
endmodule

// File: tb/tb_dual_ram_be.sv
// Scoreboard bench for dual_ram_be: three instances (latency-1 with clear,
// latency-2 non-power-of-2 depth with clear, latency-1 without clear).
module tb_dual_ram_be;

    logic        clk;
    logic        rst    [3];
    logic        wen    [3];
    logic [3:0]  wbe    [3];
    logic [3:0]  waddr  [3];
    logic [31:0] wdata  [3];
    logic        ren    [3];
    logic [3:0]  raddr  [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        busy   [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    dual_ram_be_if #(.DW(32), .ADDR_BIT(4)) bus_a ();
    dual_ram_be_if #(.DW(32), .ADDR_BIT(4)) bus_b ();
    dual_ram_be_if #(.DW(32), .ADDR_BIT(4)) bus_c ();

    assign bus_a.wen_i = wen[0];   assign bus_a.wbe_i = wbe[0];   assign bus_a.waddr_i = waddr[0];
    assign bus_a.wdata_i = wdata[0]; assign bus_a.ren_i = ren[0]; assign bus_a.raddr_i = raddr[0];
    assign rdata[0] = bus_a.rdata_o; assign rvalid[0] = bus_a.rvalid_o; assign busy[0] = bus_a.busy_o;

    assign bus_b.wen_i = wen[1];   assign bus_b.wbe_i = wbe[1];   assign bus_b.waddr_i = waddr[1];
    assign bus_b.wdata_i = wdata[1]; assign bus_b.ren_i = ren[1]; assign bus_b.raddr_i = raddr[1];
    assign rdata[1] = bus_b.rdata_o; assign rvalid[1] = bus_b.rvalid_o; assign busy[1] = bus_b.busy_o;

    assign bus_c.wen_i = wen[2];   assign bus_c.wbe_i = wbe[2];   assign bus_c.waddr_i = waddr[2];
    assign bus_c.wdata_i = wdata[2]; assign bus_c.ren_i = ren[2]; assign bus_c.raddr_i = raddr[2];
    assign rdata[2] = bus_c.rdata_o; assign rvalid[2] = bus_c.rvalid_o; assign busy[2] = bus_c.busy_o;

    dual_ram_be #(.DW(32), .DEPTH(16), .ADDR_BIT(4), .RD_PIPE(0), .CLEAR_ON_RST(1))
        dut_a (.clk(clk), .rst(rst[0]), .bus(bus_a));
    dual_ram_be #(.DW(32), .DEPTH(12), .ADDR_BIT(4), .RD_PIPE(1), .CLEAR_ON_RST(1))
        dut_b (.clk(clk), .rst(rst[1]), .bus(bus_b));
    dual_ram_be #(.DW(32), .DEPTH(16), .ADDR_BIT(4), .RD_PIPE(0), .CLEAR_ON_RST(0))
        dut_c (.clk(clk), .rst(rst[2]), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic mon(input int k, input logic [31:0] act);
        int          n;
        logic [31:0] e;
        case (k)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL rvalid_unexpected dut=%0d actual=%h required=no_rvalid", k, act);
        end else begin
            case (k)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            check($sformatf("rdata_dut%0d", k), act, e);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid[0]) mon(0, rdata[0]);
        if (rvalid[1]) mon(1, rdata[1]);
        if (rvalid[2]) mon(2, rdata[2]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        wen[k] = 1'b1; waddr[k] = a; wbe[k] = be; wdata[k] = d;
        tick();
        wen[k] = 1'b0; wbe[k] = '0;
    endtask

    task automatic rd(input int k, input logic [3:0] a, input logic [31:0] e);
        ren[k] = 1'b1; raddr[k] = a;
        push(k, e);
        tick();
        ren[k] = 1'b0;
    endtask

    task automatic collide(input int k, input logic [3:0] a, input logic [3:0] be,
                           input logic [31:0] d, input logic [31:0] e);
        wen[k] = 1'b1; waddr[k] = a; wbe[k] = be; wdata[k] = d;
        ren[k] = 1'b1; raddr[k] = a;
        push(k, e);
        tick();
        wen[k] = 1'b0; wbe[k] = '0; ren[k] = 1'b0;
    endtask

    task automatic wait_clear(input int k, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (busy[k] && cnt < 100) begin
            cnt++;
            tick();
        end
        check($sformatf("busy_cycles_dut%0d", k), 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; wen[k] = 1'b0; wbe[k] = '0; waddr[k] = '0;
            wdata[k] = '0; ren[k] = 1'b0; raddr[k] = '0;
        end
        tick();
        tick();

        // Instance A: clear length, reset state, requests ignored while busy
        ren[0] = 1'b1; raddr[0] = 4'd5;
        tick();
        check("a_rst_rdata", rdata[0], 32'h0);
        check("a_rst_rvalid", 32'(rvalid[0]), 32'h0);
        check("a_rst_busy", 32'(busy[0]), 32'h1);
        rst[0] = 1'b0;
        wait_clear(0, 16);
        push(0, 32'h0000_0000);
        tick();
        ren[0] = 1'b0;

        // Byte enables
        wr(0, 4'd3, 4'hF, 32'hAABB_CCDD);
        wr(0, 4'd3, 4'b0101, 32'h1122_3344);
        rd(0, 4'd3, 32'hAA22_CC44);

        // Collision forwarding, byte-enable-zero write, hold after read
        wr(0, 4'd7, 4'hF, 32'h1234_5678);
        collide(0, 4'd7, 4'b1100, 32'hDEAD_BEEF, 32'hDEAD_5678);
        wr(0, 4'd7, 4'h0, 32'hFFFF_FFFF);
        rd(0, 4'd7, 32'hDEAD_5678);
        tick();
        tick();
        check("a_hold_rdata", rdata[0], 32'hDEAD_5678);
        check("a_hold_rvalid", 32'(rvalid[0]), 32'h0);

        // Reset mid-clear restarts the full clear
        wr(0, 4'd9, 4'hF, 32'hCAFE_F00D);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (8) tick();
        check("a_midclear_busy", 32'(busy[0]), 32'h1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        wait_clear(0, 16);
        rd(0, 4'd9, 32'h0);
        rd(0, 4'd3, 32'h0);
        repeat (3) tick();

        // Instance B: depth 12, two-cycle latency
        rst[1] = 1'b0;
        wait_clear(1, 12);
        for (int i = 0; i < 4; i++) wr(1, 4'(i), 4'hF, 32'(10 + i));
        ren[1] = 1'b1; raddr[1] = 4'd0; push(1, 32'd10);
        tick();
        check("b_lat_n1_rvalid", 32'(rvalid[1]), 32'h0);
        raddr[1] = 4'd1; push(1, 32'd11);
        tick();
        check("b_lat_n2_rvalid", 32'(rvalid[1]), 32'h1);
        raddr[1] = 4'd2; push(1, 32'd12);
        wen[1] = 1'b1; waddr[1] = 4'd1; wbe[1] = 4'hF; wdata[1] = 32'd99;
        tick();
        wen[1] = 1'b0; wbe[1] = '0;
        raddr[1] = 4'd3; push(1, 32'd13);
        tick();
        ren[1] = 1'b0;
        repeat (3) tick();
        rd(1, 4'd1, 32'd99);

        wr(1, 4'd7, 4'hF, 32'h1234_5678);
        collide(1, 4'd7, 4'b1100, 32'hDEAD_BEEF, 32'hDEAD_5678);
        wr(1, 4'd13, 4'hF, 32'hAAAA_AAAA);
        rd(1, 4'd13, 32'h0);
        collide(1, 4'd14, 4'hF, 32'h5555_5555, 32'h0);
        rd(1, 4'd7, 32'hDEAD_5678);
        repeat (4) tick();

        // In-flight read discarded by reset
        ren[1] = 1'b1; raddr[1] = 4'd7;
        tick();
        ren[1] = 1'b0;
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        wait_clear(1, 12);
        rd(1, 4'd7, 32'h0);
        repeat (4) tick();

        // Instance C: no clear, usable in the first cycle
        check("c_rst_busy", 32'(busy[2]), 32'h0);
        rst[2] = 1'b0;
        wen[2] = 1'b1; waddr[2] = 4'd2; wbe[2] = 4'hF; wdata[2] = 32'h0000_FFFF;
        check("c_busy_release", 32'(busy[2]), 32'h0);
        tick();
        wen[2] = 1'b0; wbe[2] = '0;
        rd(2, 4'd2, 32'h0000_FFFF);
        repeat (4) tick();

        check("pending_reads", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
